// File: rtl/regfile_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_alu_sequencer_if
// Groups the two handshake channels of the register-file/ALU sequencer.
//   Command channel (instruction source -> sequencer):
//     cmd_valid, cmd_ra, cmd_rb, cmd_rw, cmd_op, cmd_we  forward
//     cmd_ready                                          backward
//   Response channel (sequencer -> result consumer):
//     rsp_valid, rsp_f, rsp_fr                           forward
//     rsp_ready                                          backward
// modport master : the instruction source / result consumer side
// modport slave  : the sequencer side
// ---------------------------------------------------------------------------
interface regfile_alu_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [ADDR_W-1:0] cmd_rw;
  logic [OP_W-1:0]   cmd_op;
  logic              cmd_we;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_f;
  logic [3:0]        rsp_fr;

  modport master (
    output cmd_valid, cmd_ra, cmd_rb, cmd_rw, cmd_op, cmd_we, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_f, rsp_fr
  );

  modport slave (
    input  cmd_valid, cmd_ra, cmd_rb, cmd_rw, cmd_op, cmd_we, rsp_ready,
    output cmd_ready, rsp_valid, rsp_f, rsp_fr
  );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_alu_sequencer
// Control sequencer for a register-file/ALU datapath. Accepts one command at
// a time, steps it through register-read, ALU-execute and write-back with
// one-cycle enables, then offers the ALU result and flags on a response
// channel. One operation takes 5 cycles; there is no overlap.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus (slave)     command and response handshake channels
//   dp_r_addr_a/b   register read addresses      (held from acceptance)
//   dp_w_addr       register write-back address  (held from acceptance)
//   dp_alu_op       ALU opcode                   (held from acceptance)
//   dp_en_rr        register-read enable, one cycle
//   dp_en_f         ALU result/flag latch enable, one cycle
//   dp_en_wb        write-back enable, one cycle
//   dp_reg_write    write strobe qualifier, only during write-back
//   dp_f, dp_fr     ALU result and flags from the datapath
//   op_count        completed operations, wraps
// ---------------------------------------------------------------------------
module regfile_alu_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  regfile_alu_sequencer_if.slave bus,
  output logic [ADDR_W-1:0] dp_r_addr_a,
  output logic [ADDR_W-1:0] dp_r_addr_b,
  output logic [ADDR_W-1:0] dp_w_addr,
  output logic [OP_W-1:0]   dp_alu_op,
  output logic              dp_en_rr,
  output logic              dp_en_f,
  output logic              dp_en_wb,
  output logic              dp_reg_write,
  input  logic [DATA_W-1:0] dp_f,
  input  logic [3:0]        dp_fr,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RR   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  logic [2:0]        state;
  logic              we_q;
  logic [DATA_W-1:0] rsp_f_q;
  logic [3:0]        rsp_fr_q;

  // Phase sequencing. Commands are only taken in IDLE; the response state
  // waits indefinitely for the consumer, which is what provides backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.cmd_valid) state <= S_RR;
        S_RR:    state <= S_EX;
        S_EX:    state <= S_WB;
        S_WB:    state <= S_RSP;
        S_RSP:   if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command fields are latched at acceptance and held until the next
  // acceptance, so the datapath sees stable addresses for the whole operation
  // and in between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_r_addr_a <= '0;
      dp_r_addr_b <= '0;
      dp_w_addr   <= '0;
      dp_alu_op   <= '0;
      we_q        <= 1'b0;
    end else if (state == S_IDLE && bus.cmd_valid) begin
      dp_r_addr_a <= bus.cmd_ra;
      dp_r_addr_b <= bus.cmd_rb;
      dp_w_addr   <= bus.cmd_rw;
      dp_alu_op   <= bus.cmd_op;
      we_q        <= bus.cmd_we;
    end
  end

  // The datapath result is valid during write-back (latched there by the
  // previous dp_en_f), so it is captured on the edge leaving WB and then held
  // for as long as the response waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_f_q  <= '0;
      rsp_fr_q <= '0;
    end else if (state == S_WB) begin
      rsp_f_q  <= dp_f;
      rsp_fr_q <= dp_fr;
    end
  end

  // An operation counts as completed when its response is handed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (state == S_RSP && bus.rsp_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  // Handshake flags and phase enables decode the state register only, so
  // there is no combinational path from cmd_valid or rsp_ready to outputs.
  // Register 0 is hard-wired, so write-back to it is never strobed.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RSP);
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_fr    = rsp_fr_q;
  assign dp_en_rr      = (state == S_RR);
  assign dp_en_f       = (state == S_EX);
  assign dp_en_wb      = (state == S_WB);
  assign dp_reg_write  = (state == S_WB) && we_q && (dp_w_addr != '0);

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_alu_sequencer
// Directed self-checking bench for regfile_alu_sequencer. Inputs change and
// outputs are sampled on the falling clock edge. The operation counter is
// instantiated 8 bits wide so that its wraparound is reachable quickly.
// ---------------------------------------------------------------------------
module tb_regfile_alu_sequencer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] dp_r_addr_a, dp_r_addr_b, dp_w_addr;
  logic [OP_W-1:0]   dp_alu_op;
  logic              dp_en_rr, dp_en_f, dp_en_wb, dp_reg_write;
  logic [DATA_W-1:0] dp_f;
  logic [3:0]        dp_fr;
  logic [CNT_W-1:0]  op_count;

  int               vectors     = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_count   = '0;

  regfile_alu_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  regfile_alu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dp_r_addr_a  (dp_r_addr_a),
    .dp_r_addr_b  (dp_r_addr_b),
    .dp_w_addr    (dp_w_addr),
    .dp_alu_op    (dp_alu_op),
    .dp_en_rr     (dp_en_rr),
    .dp_en_f      (dp_en_f),
    .dp_en_wb     (dp_en_wb),
    .dp_reg_write (dp_reg_write),
    .dp_f         (dp_f),
    .dp_fr        (dp_fr),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // {en_rr, en_f, en_wb, reg_write, rsp_valid, cmd_ready}
  wire [5:0]  ctrl  = {dp_en_rr, dp_en_f, dp_en_wb, dp_reg_write, bus.rsp_valid, bus.cmd_ready};
  // {r_addr_a, r_addr_b, w_addr, alu_op}
  wire [18:0] addrs = {dp_r_addr_a, dp_r_addr_b, dp_w_addr, dp_alu_op};

  task automatic drive_cmd(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                           input logic [3:0] op, input logic we);
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rw    = rw;
    bus.cmd_op    = op;
    bus.cmd_we    = we;
    bus.cmd_valid = 1'b1;
  endtask

  // Runs one full operation from IDLE with rsp_ready high; ends in IDLE.
  task automatic run_op(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                        input logic [3:0] op, input logic we);
    drive_cmd(ra, rb, rw, op, we);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    exp_count = exp_count + 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_cmd(5'd9, 5'd10, 5'd11, 4'd6, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++; if (ctrl !== 6'b000001) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, 6'b000001); end
    vectors++; if (addrs !== 19'd0) begin miscompares++; $display("[TB] FAIL reset_addrs: got %h expected 0", addrs); end
    vectors++; if ({op_count, bus.rsp_f, bus.rsp_fr} !== '0) begin miscompares++; $display("[TB] FAIL reset_data: count %h f %h fr %h expected all 0", op_count, bus.rsp_f, bus.rsp_fr); end
    repeat (2) @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (ctrl !== 6'b000001) begin miscompares++; $display("[TB] FAIL post_reset_idle[%0d]: got %b expected %b", i, ctrl, 6'b000001); end
    end
  endtask

  task automatic test_single_add();
    bus.rsp_ready = 1'b1;
    dp_f  = 32'h0000_0005;
    dp_fr = 4'h2;
    drive_cmd(5'd0, 5'd1, 5'd2, 4'd0, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vectors++; if (ctrl !== 6'b100000) begin miscompares++; $display("[TB] FAIL add_rr: got %b expected %b", ctrl, 6'b100000); end
    vectors++; if (addrs !== {5'd0, 5'd1, 5'd2, 4'd0}) begin miscompares++; $display("[TB] FAIL add_addrs: got %h expected %h", addrs, {5'd0, 5'd1, 5'd2, 4'd0}); end
    @(negedge clk);
    vectors++; if (ctrl !== 6'b010000) begin miscompares++; $display("[TB] FAIL add_ex: got %b expected %b", ctrl, 6'b010000); end
    @(negedge clk);
    vectors++; if (ctrl !== 6'b001100) begin miscompares++; $display("[TB] FAIL add_wb: got %b expected %b", ctrl, 6'b001100); end
    @(negedge clk);
    vectors++; if (ctrl !== 6'b000010) begin miscompares++; $display("[TB] FAIL add_rsp: got %b expected %b", ctrl, 6'b000010); end
    vectors++; if ({bus.rsp_f, bus.rsp_fr} !== {32'h0000_0005, 4'h2}) begin miscompares++; $display("[TB] FAIL add_result: got %h/%h expected 00000005/2", bus.rsp_f, bus.rsp_fr); end
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    vectors++; if (ctrl !== 6'b000001) begin miscompares++; $display("[TB] FAIL add_idle: got %b expected %b", ctrl, 6'b000001); end
    vectors++; if (op_count !== exp_count) begin miscompares++; $display("[TB] FAIL add_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    dp_f  = 32'h1234_5678;
    dp_fr = 4'h9;
    drive_cmd(5'd3, 5'd4, 5'd5, 4'd1, 1'b1);
    @(negedge clk);
    vectors++; if (addrs !== {5'd3, 5'd4, 5'd5, 4'd1}) begin miscompares++; $display("[TB] FAIL b2b_first_addrs: got %h expected %h", addrs, {5'd3, 5'd4, 5'd5, 4'd1}); end
    // second command presented while the first is still in flight
    drive_cmd(5'd1, 5'd2, 5'd3, 4'd2, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      vectors++; if ({addrs, bus.cmd_ready} !== {5'd3, 5'd4, 5'd5, 4'd1, 1'b0}) begin miscompares++; $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", i, {addrs, bus.cmd_ready}, {5'd3, 5'd4, 5'd5, 4'd1, 1'b0}); end
    end
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    vectors++; if (ctrl !== 6'b000001) begin miscompares++; $display("[TB] FAIL b2b_gap_idle: got %b expected %b", ctrl, 6'b000001); end
    vectors++; if (addrs !== {5'd3, 5'd4, 5'd5, 4'd1}) begin miscompares++; $display("[TB] FAIL b2b_gap_addrs: got %h expected %h", addrs, {5'd3, 5'd4, 5'd5, 4'd1}); end
    vectors++; if (op_count !== exp_count) begin miscompares++; $display("[TB] FAIL b2b_count1: got %0d expected %0d", op_count, exp_count); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vectors++; if (ctrl !== 6'b100000) begin miscompares++; $display("[TB] FAIL b2b_second_rr: got %b expected %b", ctrl, 6'b100000); end
    vectors++; if (addrs !== {5'd1, 5'd2, 5'd3, 4'd2}) begin miscompares++; $display("[TB] FAIL b2b_second_addrs: got %h expected %h", addrs, {5'd1, 5'd2, 5'd3, 4'd2}); end
    repeat (3) @(negedge clk);
    vectors++; if ({ctrl, bus.rsp_f} !== {6'b000010, 32'h1234_5678}) begin miscompares++; $display("[TB] FAIL b2b_second_rsp: got %h expected %h", {ctrl, bus.rsp_f}, {6'b000010, 32'h1234_5678}); end
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    vectors++; if (op_count !== exp_count) begin miscompares++; $display("[TB] FAIL b2b_count2: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_zero_write();
    for (int i = 0; i < 2; i++) begin
      // case 0: write to register 0 requested; case 1: no write requested
      drive_cmd(5'd4, 5'd5, (i == 0) ? 5'd0 : 5'd7, 4'd3, (i == 0));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (ctrl !== 6'b001000) begin miscompares++; $display("[TB] FAIL zero_write_wb[%0d]: got %b expected %b", i, ctrl, 6'b001000); end
      repeat (2) @(negedge clk);
      exp_count = exp_count + 1'b1;
    end
    vectors++; if (op_count !== exp_count) begin miscompares++; $display("[TB] FAIL zero_write_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    dp_f  = 32'hDEAD_BEEF;
    dp_fr = 4'hA;
    drive_cmd(5'd6, 5'd7, 5'd8, 4'd4, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    dp_f  = 32'h0000_0000;
    dp_fr = 4'h0;
    for (int i = 0; i < 10; i++) begin
      vectors++; if ({ctrl, bus.rsp_f, bus.rsp_fr, op_count} !== {6'b000010, 32'hDEAD_BEEF, 4'hA, exp_count}) begin miscompares++; $display("[TB] FAIL bp_hold[%0d]: ctrl %b f %h fr %h count %0d expected 000010 deadbeef a %0d", i, ctrl, bus.rsp_f, bus.rsp_fr, op_count, exp_count); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    vectors++; if ({ctrl, op_count} !== {6'b000001, exp_count}) begin miscompares++; $display("[TB] FAIL bp_release: ctrl %b count %0d expected 000001 %0d", ctrl, op_count, exp_count); end
    // rsp_ready held high while idle must not count anything
    repeat (3) @(negedge clk);
    vectors++; if (op_count !== exp_count) begin miscompares++; $display("[TB] FAIL rsp_ready_idle: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_wrap();
    dp_f = 32'h0000_0077;
    while (exp_count != {CNT_W{1'b1}}) run_op(5'd2, 5'd3, 5'd4, 4'd5, 1'b1);
    vectors++; if (op_count !== 8'hFF) begin miscompares++; $display("[TB] FAIL wrap_max: got %h expected ff", op_count); end
    run_op(5'd2, 5'd3, 5'd4, 4'd5, 1'b1);
    vectors++; if (op_count !== 8'h00) begin miscompares++; $display("[TB] FAIL wrap_zero: got %h expected 00", op_count); end
    run_op(5'd2, 5'd3, 5'd4, 4'd5, 1'b1);
    vectors++; if (op_count !== 8'h01) begin miscompares++; $display("[TB] FAIL wrap_one: got %h expected 01", op_count); end
  endtask

  task automatic test_abort();
    drive_cmd(5'd1, 5'd1, 5'd1, 4'd5, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    vectors++; if (ctrl !== 6'b010000) begin miscompares++; $display("[TB] FAIL abort_ex: got %b expected %b", ctrl, 6'b010000); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({ctrl, op_count, bus.rsp_f, addrs} !== {6'b000001, 8'h00, 32'h0, 19'h0}) begin miscompares++; $display("[TB] FAIL abort_reset: ctrl %b count %h f %h addrs %h expected 000001 00 0 0", ctrl, op_count, bus.rsp_f, addrs); end
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if ({ctrl, op_count} !== {6'b000001, exp_count}) begin miscompares++; $display("[TB] FAIL abort_quiet[%0d]: ctrl %b count %0d expected 000001 0", i, ctrl, op_count); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_rw    = '0;
    bus.cmd_op    = '0;
    bus.cmd_we    = 1'b0;
    bus.rsp_ready = 1'b0;
    dp_f          = '0;
    dp_fr         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_zero_write();
    test_backpressure();
    test_wrap();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
